// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit.
// Define UART_TX_HOLD_EN to add a one-entry hold buffer for back-to-back frames with zero gap.
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  ready,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  par_en;
    logic                  par_typ;
    logic [PRESCALE_W-1:0] presc;
  } frame_t;

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BW-1:0]         bit_q, bit_d;
  frame_t                frm_q, frm_d, in_frm;
  logic                  tx_q, tx_d;
  logic                  accept, bit_done, start_in;

`ifdef UART_TX_HOLD_EN
  frame_t hold_q, hold_d;
  logic   hold_vld_q, hold_vld_d;
  logic   start_hold;
  assign ready = (state_q == IDLE) || !hold_vld_q;
`else
  assign ready = (state_q == IDLE);
`endif

  assign in_frm   = '{data: P_DATA, par_en: PAR_EN, par_typ: PAR_TYP, presc: prescale};
  assign accept   = DATA_VALID && ready;
  // prescale 0 wraps to all-ones here, giving a full 2^PRESCALE_W clock bit.
  assign bit_done = (edge_q == (frm_q.presc - PRESCALE_W'(1)));
  assign busy     = (state_q != IDLE);
  assign TX_OUT   = tx_q;

  always_comb begin
    state_d  = state_q;
    edge_d   = edge_q;
    bit_d    = bit_q;
    frm_d    = frm_q;
    start_in = 1'b0;
`ifdef UART_TX_HOLD_EN
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    start_hold = 1'b0;
`endif
    if (state_q != IDLE) edge_d = bit_done ? '0 : edge_q + 1'b1;

    case (state_q)
      IDLE:   start_in = accept;
      START:  if (bit_done) begin
                state_d = DATA;
                bit_d   = '0;
              end
      DATA:   if (bit_done) begin
                if (bit_q == BW'(DATA_WIDTH - 1)) state_d = frm_q.par_en ? PARITY : STOP;
                else                              bit_d   = bit_q + 1'b1;
              end
      PARITY: if (bit_done) state_d = STOP;
      STOP:   if (bit_done) begin
                state_d = IDLE;
`ifdef UART_TX_HOLD_EN
                // A byte arriving on the last stop clock with hold empty chains directly.
                if (hold_vld_q) start_hold = 1'b1;
                else            start_in   = accept;
`endif
              end
      default: state_d = IDLE;
    endcase

`ifdef UART_TX_HOLD_EN
    if (accept && (state_q != IDLE) && !start_in) begin
      hold_d     = in_frm;
      hold_vld_d = 1'b1;
    end
    if (start_hold) begin
      frm_d      = hold_q;
      hold_vld_d = 1'b0;
      state_d    = START;
      edge_d     = '0;
      bit_d      = '0;
    end
`endif
    if (start_in) begin
      frm_d   = in_frm;
      state_d = START;
      edge_d  = '0;
      bit_d   = '0;
    end

    // Line level is registered from the next state so TX_OUT tracks state_q.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = frm_d.data[bit_d];
      PARITY:  tx_d = (^frm_d.data) ^ frm_d.par_typ;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      edge_q  <= '0;
      bit_q   <= '0;
      frm_q   <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_HOLD_EN
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      frm_q   <= frm_d;
      tx_q    <= tx_d;
`ifdef UART_TX_HOLD_EN
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset/idle, framing with and without parity, mid-frame
// input changes, reset mid-frame and back-to-back frames at prescale 0.
module tb_uart_tx;

`ifdef UART_TX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] prescale = 6'd16;
  logic       ready, TX_OUT, busy;

  int n_chk  = 0;
  int n_fail = 0;

  uart_tx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .clk(clk), .rst(rst), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .ready(ready),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .prescale(prescale), .TX_OUT(TX_OUT), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; checks every clock of the frame and the idle clock after.
  task automatic frame(input string tag, input logic [7:0] b, input logic pe, input logic pt,
                       input logic [5:0] ps, input logic exp_par, input int chg_at);
    logic [10:0] bits;
    int p, nb;
    p    = (ps == 6'd0) ? 64 : int'(ps);
    nb   = pe ? 11 : 10;
    bits = pe ? {1'b1, exp_par, b, 1'b0} : {2'b11, b, 1'b0};
    chk({tag, " ready_pre"}, ready, 1'b1);
    DATA_VALID = 1'b1; P_DATA = b; PAR_EN = pe; PAR_TYP = pt; prescale = ps;
    for (int k = 1; k <= nb * p; k++) begin
      @(negedge clk);
      if (k == 1) DATA_VALID = 1'b0;
      if (k == chg_at) begin prescale = 6'd8; PAR_EN = 1'b1; end
      chk($sformatf("%s tx[%0d]", tag, k), TX_OUT, bits[(k - 1) / p]);
      chk($sformatf("%s busy[%0d]", tag, k), busy, 1'b1);
      chk($sformatf("%s ready[%0d]", tag, k), ready, HOLD);
    end
    @(negedge clk);
    chk({tag, " tx_end"}, TX_OUT, 1'b1);
    chk({tag, " busy_end"}, busy, 1'b0);
    chk({tag, " ready_end"}, ready, 1'b1);
  endtask

  initial begin
    logic [9:0] f;
    bit exp_tx[$];
    bit exp_bz[$];
    int drop;

    // reset held for 3 clocks
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst tx", TX_OUT, 1'b1);
      chk("rst busy", busy, 1'b0);
      chk("rst ready", ready, 1'b1);
    end
    rst = 1'b1;
    repeat (100) begin
      @(negedge clk);
      chk("idle tx", TX_OUT, 1'b1);
      chk("idle busy", busy, 1'b0);
      chk("idle ready", ready, 1'b1);
    end

    // 0xA5 no parity: line 0,1,0,1,0,0,1,0,1,1
    frame("a5_np", 8'hA5, 1'b0, 1'b0, 6'd16, 1'b0, 0);
    frame("a5_even", 8'hA5, 1'b1, 1'b0, 6'd16, 1'b0, 0);
    frame("a5_odd", 8'hA5, 1'b1, 1'b1, 6'd16, 1'b1, 0);
    frame("07_even", 8'h07, 1'b1, 1'b0, 6'd4, 1'b1, 0);
    frame("3c_p1", 8'h3C, 1'b0, 1'b0, 6'd1, 1'b0, 0);
    // prescale/PAR_EN changed during D1 must not affect the frame
    frame("midchg", 8'hA5, 1'b0, 1'b0, 6'd16, 1'b0, 40);

    // reset during D3 (cycles 65..80) of 0xA5, where the line is 0
    DATA_VALID = 1'b1; P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd16;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (k == 1) DATA_VALID = 1'b0;
    end
    chk("d3 tx", TX_OUT, 1'b0);
    chk("d3 busy", busy, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort tx", TX_OUT, 1'b1);
    chk("abort busy", busy, 1'b0);
    chk("abort ready", ready, 1'b1);
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("post_abort tx", TX_OUT, 1'b1);
      chk("post_abort busy", busy, 1'b0);
    end

    // back-to-back 0x01 then 0xFF with DATA_VALID held, prescale 0 (64 clocks/bit)
    f = {1'b1, 8'h01, 1'b0};
    for (int i = 0; i < 10; i++) repeat (64) begin exp_tx.push_back(f[i]); exp_bz.push_back(1'b1); end
    if (!HOLD) begin exp_tx.push_back(1'b1); exp_bz.push_back(1'b0); end
    f = {1'b1, 8'hFF, 1'b0};
    for (int i = 0; i < 10; i++) repeat (64) begin exp_tx.push_back(f[i]); exp_bz.push_back(1'b1); end
    drop = HOLD ? 2 : 642;
    chk("b2b ready_pre", ready, 1'b1);
    DATA_VALID = 1'b1; P_DATA = 8'h01; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd0;
    for (int k = 1; k <= exp_tx.size(); k++) begin
      @(negedge clk);
      if (k == 1) P_DATA = 8'hFF;
      if (k == drop) DATA_VALID = 1'b0;
      chk($sformatf("b2b tx[%0d]", k), TX_OUT, exp_tx[k - 1]);
      chk($sformatf("b2b busy[%0d]", k), busy, exp_bz[k - 1]);
    end
    @(negedge clk);
    chk("b2b tx_end", TX_OUT, 1'b1);
    chk("b2b busy_end", busy, 1'b0);
    chk("b2b ready_end", ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the team's UART: accepts a byte over a valid/ready handshake and shifts out start bit, 8 data bits LSB first, optional parity bit and one stop bit on `TX_OUT`. Bit period and framing use the same `prescale`, `PAR_EN` and `PAR_TYP` conventions as the UART receive path, so a `uart_tx` output looped into the receiver decodes with `parity_error = 0` and `stop_error = 0`. Sits between the byte source (register file or FIFO) and the serial pin.

## Interface

- `DATA_WIDTH`, 8: data bits per frame.
- `PRESCALE_W`, 6: width of `prescale`.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `P_DATA`  in  `DATA_WIDTH`  byte to send; sampled on acceptance.
- `DATA_VALID`  in  1  source has a byte on `P_DATA`.
- `ready`  out  1  block can accept a byte this cycle.
- `PAR_EN`  in  1  1 = insert parity bit.
- `PAR_TYP`  in  1  0 = even, parity bit = XOR of data; 1 = odd, parity bit = XNOR of data.
- `prescale`  in  `PRESCALE_W`  clocks per bit; 0 means 2^`PRESCALE_W` (64).
- `TX_OUT`  out  1  serial line, registered, idle high.
- `busy`  out  1  frame in progress, start bit through last stop clock.

## Operation

- Acceptance: `DATA_VALID && ready` on a rising edge. `P_DATA`, `PAR_EN`, `PAR_TYP` and `prescale` are latched into frame registers at that edge. Input changes after that edge do not affect the frame in flight.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on acceptance.
  - START -> DATA after one bit period.
  - DATA -> PARITY after `DATA_WIDTH` bit periods if the latched `PAR_EN` = 1; otherwise DATA -> STOP.
  - PARITY -> STOP after one bit period.
  - STOP -> IDLE after one bit period. With the hold buffer full, STOP goes directly to START instead (see Configuration).
- Line levels per state: START drives 0. DATA drives data[i], LSB first. PARITY drives the computed parity of the latched byte. STOP and IDLE drive 1.
- Edge counter: counts 0..P-1 within each bit, where P is the latched prescale, or 64 if it is 0. It advances the bit counter and wraps at P-1, matching the receiver's counter.
- Frame length: 10 bits with parity off, 11 with parity on. Total clocks = bits × P.
- `ready`:
  - Without hold: `ready` = (state == IDLE).
  - `busy` = (state != IDLE).
- Reset:
  - In reset: `TX_OUT` = 1, `busy` = 0, `ready` = 1, state IDLE, counters 0, hold buffer empty.
  - Reset asserted mid-frame aborts the frame. `TX_OUT` is 1 from the next edge, and no partial frame resumes.
- `DATA_VALID` while `ready` = 0 is ignored. The source must hold it until accepted.

## Timing

- Acceptance at edge t: `TX_OUT` falls and `busy` rises at edge t+1. Latency is 1 clock.
- Each bit lasts exactly P clocks. For example, P = 16: the start bit is clocks t+1..t+16, and D0 is t+17..t+32.
- Last stop clock at edge T: state is IDLE at T+1 with `busy` = 0 and `ready` = 1. A byte accepted at T+1 starts at T+2. Without hold, the minimum inter-frame gap is 1 idle clock.
- `ready` falls at edge t+1 after acceptance, so a byte cannot be accepted on two consecutive edges (no-hold build).

## Configuration

- `UART_TX_HOLD_EN` defined: adds a one-entry hold buffer for byte, `PAR_EN`, `PAR_TYP` and `prescale`.
  - `ready` = (state == IDLE) || hold empty.
  - A byte accepted while busy is stored in the hold buffer.
  - On the last stop clock with the hold buffer full, the frame registers load from hold and START begins at the very next clock (zero gap). The hold buffer empties and `ready` rises the same edge.
  - Acceptance in IDLE with the hold buffer empty bypasses the hold buffer.
  - Reset clears the hold buffer.
- Not defined: no hold buffer; behaviour exactly as in Operation and Timing.

## Test plan

- Reset, then idle: `rst` = 0 for 3 clocks, release, `DATA_VALID` = 0 for 100 clocks -> `TX_OUT` = 1, `busy` = 0, `ready` = 1 throughout.
- Single frame: P_DATA = 0xA5, PAR_EN = 0, prescale = 16 -> 160 clocks total. Line sequence is 0,1,0,1,0,0,1,0,1,1, each level held 16 clocks. `busy` drops after clock 160.
- Parity: 0xA5 (four ones) with PAR_EN = 1 -> parity bit 0 when PAR_TYP = 0 and 1 when PAR_TYP = 1, 176 clocks. Loopback into the receiver -> P_DATA = 0xA5, parity_error = 0, stop_error = 0.
- Mid-frame changes: change `prescale` to 8 and `PAR_EN` to 1 during the DATA state -> the current frame keeps 16 clocks per bit and no parity. Reset asserted in bit D3 -> `TX_OUT` = 1 the next clock, `busy` = 0.
- Back-to-back: hold `DATA_VALID` high with 0x01 then 0xFF, prescale = 0.
  - 64 clocks per bit.
  - Without `UART_TX_HOLD_EN`: 1 idle clock between stop and start.
  - With `UART_TX_HOLD_EN`: 0xFF is accepted during the first frame and starts with zero gap.
